// File: rtl/wb_hub_pkg.sv
// ---------------------------------------------------------------------------
// wb_hub_pkg
// Shared definitions for the Wishbone multi-slave hub:
//   - hub_state_t          : transfer FSM states
//   - DATA_W               : Wishbone data width
//   - OFS_*                : local register offsets inside slot 0
//   - DEFAULT_READ_VALUE_C : data returned on timeout / unmapped access
//   - sat_inc8()           : saturating 8-bit increment for the timeout count
// ---------------------------------------------------------------------------
package wb_hub_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] DEFAULT_READ_VALUE_C = 32'hBADF_ABAC;

    localparam int unsigned OFS_ID          = 32'h00;
    localparam int unsigned OFS_INTR_STATUS = 32'h04;
    localparam int unsigned OFS_INTR_MASK   = 32'h08;
    localparam int unsigned OFS_TIMEOUT     = 32'h0C;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DONE     = 2'd2
    } hub_state_t;

    // Count stops at 255 instead of wrapping so software can tell "many".
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_hub_intr_ctrl.sv
// ---------------------------------------------------------------------------
// wb_hub_intr_ctrl
// Interrupt aggregation for the hub.
//   clk, rst_n     : hub clock, asynchronous active-low reset
//   i_intr         : per-slave level interrupts (already in clk domain)
//   i_w1c_en       : write-1-to-clear strobe for the status register
//   i_w1c_bits     : bits to clear (byte lanes already applied)
//   i_mask_we      : mask register write strobe
//   i_mask_wdata   : new mask value (byte lanes already merged)
//   o_status       : sticky rising-edge status
//   o_mask         : interrupt mask
//   o_intr         : registered OR of (status & mask)
// ---------------------------------------------------------------------------
module wb_hub_intr_ctrl #(
    parameter int NUM_SLAVES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SLAVES-1:0] i_intr,
    input  logic                  i_w1c_en,
    input  logic [NUM_SLAVES-1:0] i_w1c_bits,
    input  logic                  i_mask_we,
    input  logic [NUM_SLAVES-1:0] i_mask_wdata,
    output logic [NUM_SLAVES-1:0] o_status,
    output logic [NUM_SLAVES-1:0] o_mask,
    output logic                  o_intr
);

    logic [NUM_SLAVES-1:0] r_intr_prev;
    logic [NUM_SLAVES-1:0] r_status;
    logic [NUM_SLAVES-1:0] r_mask;
    logic                  r_intr;

    logic [NUM_SLAVES-1:0] w_rise;
    logic [NUM_SLAVES-1:0] w_clear;

    assign w_rise  = i_intr & ~r_intr_prev;
    assign w_clear = i_w1c_en ? i_w1c_bits : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intr_prev <= '0;
            r_status    <= '0;
            r_mask      <= '0;
            r_intr      <= 1'b0;
        end else begin
            r_intr_prev <= i_intr;
            // Clear first, then OR in new edges: a coincident edge keeps the bit set.
            r_status    <= (r_status & ~w_clear) | w_rise;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
            r_intr      <= |(r_status & r_mask);
        end
    end

    assign o_status = r_status;
    assign o_mask   = r_mask;
    assign o_intr   = r_intr;

endmodule

// File: rtl/wb_multi_slave_hub.sv
// ---------------------------------------------------------------------------
// wb_multi_slave_hub
// Wishbone fan-out from the bridge port to NUM_SLAVES peripheral slots.
// Slot = WBs_ADR[APERWIDTH-1:SLOT_SHIFT]; slot 0 holds the hub registers,
// slot k (1..NUM_SLAVES) is slave k-1, anything above is unmapped.
// Ports:
//   WB_CLK, WB_RST_N        : clock, asynchronous active-low reset
//   WBs_ADR/CYC/STB/WE/RD   : master request (RD is informational only)
//   WBs_BYTE_STB, WBs_WR_DAT: byte enables and write data
//   WBs_RD_DAT, WBs_ACK     : registered response
//   Slv_CYC_o               : one-hot slave select (STB/WE/ADR/DAT shared)
//   Slv_RD_DAT_i, Slv_ACK_i : packed slave read data and acknowledges
//   Slv_Intr_i              : per-slave level interrupts
//   Intr_o                  : combined masked interrupt
// Local registers: 0x00 ID, 0x04 INTR_STATUS (W1C), 0x08 INTR_MASK,
// 0x0C TIMEOUT_REG ([7:0] saturating count, [15:8] last timed-out slot).
// ---------------------------------------------------------------------------
module wb_multi_slave_hub
    import wb_hub_pkg::*;
#(
    parameter int          NUM_SLAVES           = 4,
    parameter int          APERWIDTH            = 17,
    parameter int          SLOT_SHIFT           = 12,
    parameter logic [31:0] HUB_ID               = 32'h0001_0000,
    parameter logic [31:0] DEFAULT_READ_VALUE   = DEFAULT_READ_VALUE_C,
    parameter int          DEFAULT_CNTR_WIDTH   = 3,
    parameter int          DEFAULT_CNTR_TIMEOUT = 7
) (
    input  logic                         WB_CLK,
    input  logic                         WB_RST_N,
    input  logic [APERWIDTH-1:0]         WBs_ADR,
    input  logic                         WBs_CYC,
    input  logic                         WBs_STB,
    input  logic                         WBs_WE,
    input  logic                         WBs_RD,
    input  logic [3:0]                   WBs_BYTE_STB,
    input  logic [DATA_W-1:0]            WBs_WR_DAT,
    output logic [DATA_W-1:0]            WBs_RD_DAT,
    output logic                         WBs_ACK,
    output logic [NUM_SLAVES-1:0]        Slv_CYC_o,
    input  logic [DATA_W*NUM_SLAVES-1:0] Slv_RD_DAT_i,
    input  logic [NUM_SLAVES-1:0]        Slv_ACK_i,
    input  logic [NUM_SLAVES-1:0]        Slv_Intr_i,
    output logic                         Intr_o
);

    localparam int SLOT_W = APERWIDTH - SLOT_SHIFT;

    generate
        if (DEFAULT_CNTR_TIMEOUT >= (1 << DEFAULT_CNTR_WIDTH)) begin : g_bad_timeout
            $error("DEFAULT_CNTR_TIMEOUT must be below 2**DEFAULT_CNTR_WIDTH");
        end
        if (NUM_SLAVES < 1 || NUM_SLAVES > 14) begin : g_bad_slaves
            $error("NUM_SLAVES must be in 1..14");
        end
    endgenerate

    // ---------------- registers ----------------
    hub_state_t                    r_state;
    logic                          r_ack;
    logic [DATA_W-1:0]             r_rd_dat;
    logic [NUM_SLAVES-1:0]         r_slv_cyc;
    logic [DEFAULT_CNTR_WIDTH-1:0] r_cntr;
    logic [SLOT_W-1:0]             r_slot;
    logic [7:0]                    r_to_cnt;
    logic [7:0]                    r_to_slot;

    // ---------------- decode ----------------
    logic [SLOT_W-1:0]       w_slot;
    logic [SLOT_SHIFT-1:0]   w_offset;
    logic                    w_req;
    logic                    w_slot_local;
    logic                    w_slot_mapped;
    logic [NUM_SLAVES-1:0]   w_slot_onehot;
    logic                    w_local_wr;

    assign w_slot        = WBs_ADR[APERWIDTH-1:SLOT_SHIFT];
    assign w_offset      = WBs_ADR[SLOT_SHIFT-1:0];
    assign w_req         = (r_state == ST_IDLE) && WBs_CYC && WBs_STB;
    assign w_slot_local  = (w_slot == '0);
    assign w_slot_mapped = (w_slot <= SLOT_W'(NUM_SLAVES));
    assign w_local_wr    = w_req && w_slot_local && WBs_WE;

    // ---------------- slave response mux ----------------
    logic [DATA_W-1:0] w_data_terms [NUM_SLAVES];
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_ack;

    // ---------------- interrupt register interface ----------------
    logic [NUM_SLAVES-1:0] w_status;
    logic [NUM_SLAVES-1:0] w_mask;
    logic [NUM_SLAVES-1:0] w_mask_wdata;
    logic [NUM_SLAVES-1:0] w_w1c_bits;
    logic                  w_w1c_en;
    logic                  w_mask_we;
    logic                  w_intr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
            assign w_slot_onehot[gi] = (w_slot == SLOT_W'(gi + 1));
            // Only the selected slave contributes, so the OR below is a mux.
            assign w_data_terms[gi]  = r_slv_cyc[gi] ? Slv_RD_DAT_i[gi*DATA_W +: DATA_W] : '0;
            // Each register bit lives in byte lane gi/8.
            assign w_mask_wdata[gi]  = WBs_BYTE_STB[gi/8] ? WBs_WR_DAT[gi] : w_mask[gi];
            assign w_w1c_bits[gi]    = WBs_BYTE_STB[gi/8] & WBs_WR_DAT[gi];
        end
    endgenerate

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_data = w_sel_data | w_data_terms[i];
        end
    end

    assign w_sel_ack = |(Slv_ACK_i & r_slv_cyc);

    assign w_w1c_en  = w_local_wr && (w_offset == SLOT_SHIFT'(OFS_INTR_STATUS));
    assign w_mask_we = w_local_wr && (w_offset == SLOT_SHIFT'(OFS_INTR_MASK));

    // ---------------- local read mux ----------------
    logic [DATA_W-1:0] w_local_rdata;

    always_comb begin
        w_local_rdata = DEFAULT_READ_VALUE;
        if (w_offset == SLOT_SHIFT'(OFS_ID)) begin
            w_local_rdata = HUB_ID;
        end else if (w_offset == SLOT_SHIFT'(OFS_INTR_STATUS)) begin
            w_local_rdata = DATA_W'(w_status);
        end else if (w_offset == SLOT_SHIFT'(OFS_INTR_MASK)) begin
            w_local_rdata = DATA_W'(w_mask);
        end else if (w_offset == SLOT_SHIFT'(OFS_TIMEOUT)) begin
            w_local_rdata = {16'h0000, r_to_slot, r_to_cnt};
        end
    end

    // ---------------- transfer FSM ----------------
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_rd_dat  <= '0;
            r_slv_cyc <= '0;
            r_cntr    <= '0;
            r_slot    <= '0;
            r_to_cnt  <= '0;
            r_to_slot <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_slot_local) begin
                            r_ack    <= 1'b1;
                            r_rd_dat <= w_local_rdata;
                            r_state  <= ST_DONE;
                        end else if (!w_slot_mapped) begin
                            // Unmapped slots answer at once and are not timeouts.
                            r_ack    <= 1'b1;
                            r_rd_dat <= DEFAULT_READ_VALUE;
                            r_state  <= ST_DONE;
                        end else begin
                            r_slv_cyc <= w_slot_onehot;
                            r_slot    <= w_slot;
                            r_cntr    <= '0;
                            r_state   <= ST_WAIT_ACK;
                        end
                    end
                end

                ST_WAIT_ACK: begin
                    if (!WBs_CYC) begin
                        // Master gave up: release the slave silently.
                        r_slv_cyc <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_sel_ack) begin
                        // Checked before the timeout so a last-moment ACK wins.
                        r_ack     <= 1'b1;
                        r_rd_dat  <= w_sel_data;
                        r_slv_cyc <= '0;
                        r_state   <= ST_DONE;
                    end else if (r_cntr == DEFAULT_CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT)) begin
                        r_ack     <= 1'b1;
                        r_rd_dat  <= DEFAULT_READ_VALUE;
                        r_slv_cyc <= '0;
                        r_to_cnt  <= sat_inc8(r_to_cnt);
                        r_to_slot <= 8'(r_slot);
                        r_state   <= ST_DONE;
                    end else begin
                        r_cntr <= r_cntr + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_ack     <= 1'b0;
                    r_slv_cyc <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- interrupt block ----------------
    wb_hub_intr_ctrl #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_intr_ctrl (
        .clk          (WB_CLK),
        .rst_n        (WB_RST_N),
        .i_intr       (Slv_Intr_i),
        .i_w1c_en     (w_w1c_en),
        .i_w1c_bits   (w_w1c_bits),
        .i_mask_we    (w_mask_we),
        .i_mask_wdata (w_mask_wdata),
        .o_status     (w_status),
        .o_mask       (w_mask),
        .o_intr       (w_intr)
    );

    // WBs_RD carries no extra information beyond WE; upper data/lane bits
    // are unused when the interrupt registers are narrow.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{WBs_RD, WBs_WR_DAT, WBs_BYTE_STB};

    assign WBs_ACK    = r_ack;
    assign WBs_RD_DAT = r_rd_dat;
    assign Slv_CYC_o  = r_slv_cyc;
    assign Intr_o     = w_intr;

endmodule

// File: doc/wb_multi_slave_hub.md
Name: wb_multi_slave_hub

Overview:
- Parametrised Wishbone fan-out hub between the AHB-to-FPGA bridge Wishbone port and NUM_SLAVES peripheral slots (UARTs, sensor blocks, etc.).
- Decodes the aperture address into slots and routes each cycle to exactly one slave.
- Generates a fallback ACK with DEFAULT_READ_VALUE on timeout or on an unmapped slot.
- Aggregates per-slave interrupts into sticky status with a mask and one combined interrupt for FB_msg_out.

Parameters:
- NUM_SLAVES, 4, number of external slave slots (1..14).
- APERWIDTH, 17, Wishbone byte-address width.
- SLOT_SHIFT, 12, address bit where the slot index starts; slot = WBs_ADR[APERWIDTH-1:SLOT_SHIFT].
- HUB_ID, 32'h0001_0000, read-only value at local offset 0x00.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on timeout or unmapped access.
- DEFAULT_CNTR_WIDTH, 3, ACK-timeout counter width.
- DEFAULT_CNTR_TIMEOUT, 7, cycles in WAIT_ACK before a forced ACK; must be < 2**DEFAULT_CNTR_WIDTH (elaboration error otherwise).

Ports:
- WB_CLK, in, 1, hub clock.
- WB_RST_N, in, 1, asynchronous active-low reset.
- WBs_ADR, in, APERWIDTH, byte address.
- WBs_CYC, in, 1, cycle.
- WBs_STB, in, 1, strobe.
- WBs_WE, in, 1, write enable.
- WBs_RD, in, 1, read enable (informational).
- WBs_BYTE_STB, in, 4, byte enables.
- WBs_WR_DAT, in, 32, write data.
- WBs_RD_DAT, out, 32, read data.
- WBs_ACK, out, 1, transfer acknowledge.
- Slv_CYC_o, out, NUM_SLAVES, one-hot slave select; STB/WE/ADR/DAT are shared.
- Slv_RD_DAT_i, in, 32*NUM_SLAVES, packed slave read data; slave i at [32i+31:32i].
- Slv_ACK_i, in, NUM_SLAVES, slave acknowledges.
- Slv_Intr_i, in, NUM_SLAVES, level interrupts (WB_CLK domain).
- Intr_o, out, 1, registered OR of (status & mask).

Behaviour:
- Reset (WB_RST_N=0, async):
  - State=IDLE; WBs_ACK=0, WBs_RD_DAT=0, Slv_CYC_o=0, Intr_o=0.
  - INTR_STATUS=0, INTR_MASK=0, TIMEOUT_REG=0, counter=0, edge-detect history=0.
- Slot map:
  - Slot 0 = hub local registers; slot k (1..NUM_SLAVES) = slave k-1.
  - Slots > NUM_SLAVES are unmapped.
- Local registers (offset = WBs_ADR[SLOT_SHIFT-1:0]; byte lanes honoured on writes):
  - 0x00 ID: RO, HUB_ID.
  - 0x04 INTR_STATUS: W1C, [NUM_SLAVES-1:0].
  - 0x08 INTR_MASK: RW.
  - 0x0C TIMEOUT_REG: RO; [7:0] saturating timeout count, [15:8] last timed-out slot.
  - Other offsets read DEFAULT_READ_VALUE; writes to them are ignored.
- FSM states: IDLE, WAIT_ACK, DONE.
  - IDLE, CYC&STB, slot 0: perform the local access; WBs_ACK=1 and WBs_RD_DAT valid on the next edge; go to DONE. Latency 1.
  - IDLE, CYC&STB, unmapped slot: ACK next edge with DEFAULT_READ_VALUE; go to DONE. Timeout count is not incremented.
  - IDLE, CYC&STB, slot k: Slv_CYC_o[k-1]=1 from the next edge; counter cleared; go to WAIT_ACK.
  - WAIT_ACK, Slv_ACK_i[k-1]=1: register Slv_RD_DAT_i of slave k-1; WBs_ACK=1 on the next edge; Slv_CYC_o=0; go to DONE. Latency = slave latency + 1.
  - WAIT_ACK, counter == DEFAULT_CNTR_TIMEOUT without ACK: WBs_ACK=1 with DEFAULT_READ_VALUE; TIMEOUT_REG count += 1 (saturates at 255); last slot = k; Slv_CYC_o=0; go to DONE.
  - WAIT_ACK, slave ACK in the same cycle as the timeout: the ACK wins; real data is returned and the timeout is not counted.
  - WAIT_ACK, WBs_CYC drops before completion: abort to IDLE; no WBs_ACK; Slv_CYC_o=0 next edge.
  - DONE: WBs_ACK is high for exactly this one cycle; next edge returns to IDLE, WBs_ACK=0. WBs_RD_DAT holds its value until the next ACK.
  - Back-to-back transfers: a new STB is accepted in IDLE only, giving a minimum of 2 cycles between ACKs.
- Interrupts:
  - Per-slave rising-edge detect on Slv_Intr_i sets INTR_STATUS[i].
  - A set edge and a W1C to the same bit in the same cycle: set wins.
  - Intr_o is registered, one cycle after the status or mask change.

Decomposition:
- Shared package wb_hub_pkg: FSM state enum; local offset constants (0x00/0x04/0x08/0x0C); DEFAULT_READ_VALUE; the 32-bit data-width constant.
- One sub-module, wb_hub_intr_ctrl: edge detect, sticky W1C status, mask register, Intr_o.
- The FSM, decode and read mux stay in the top level.

Test Plan:
- Read local 0x00 -> WBs_ACK one cycle after STB, data=HUB_ID. Write INTR_MASK=0xF, read back 0x0000000F.
- Read slot 2 (addr 0x02000); slave 1 ACKs after 3 cycles with 0xA5A5_0001 -> Slv_CYC_o=4'b0010 during the wait; WBs_ACK 1 cycle after the slave ACK; data 0xA5A5_0001.
- Slot 3 slave never ACKs -> WBs_ACK after 7 wait cycles with 0xBAD_FAB_AC; TIMEOUT_REG=0x0000_0301. Repeat 300 times -> count saturates at 0xFF.
- Unmapped slot 9 (addr 0x09000) -> ACK in 1 cycle with 0xBAD_FAB_AC; TIMEOUT_REG unchanged.
- Slv_Intr_i[0] rises with mask=0 -> INTR_STATUS=0x1, Intr_o=0. Set mask bit 0 -> Intr_o=1 next cycle. W1C 0x1 in the same cycle as a new edge -> status stays 0x1.
- Deassert WB_RST_N during WAIT_ACK; also drop WBs_CYC mid-wait in a separate run -> Slv_CYC_o=0 and no spurious WBs_ACK in both cases; after reset all registers are 0.
